// File: rtl/toll_pkg.sv
// Shared definitions for the toll booth: upstream state codes, fare table,
// hipass card bit-field positions and the fare gate's local FSM encoding.
package toll_pkg;

  // State codes emitted by the upstream toll-booth Moore FSM
  typedef enum logic [1:0] {
    ST_INITIAL = 2'b00,
    ST_CAR     = 2'b01,
    ST_HIPASS  = 2'b10,
    ST_OUTPUT  = 2'b11
  } toll_state_e;

  // Base fare per vehicle class, units of 100 won; index 0 is class 0
  localparam logic [3:0][7:0] FARE_TABLE = {8'd40, 8'd30, 8'd20, 8'd10};

  // Hipass card code bit fields
  localparam int HP_CLASS_LSB  = 0;
  localparam int HP_CLASS_MSB  = 1;
  localparam int HP_EXEMPT_BIT = 2;
  localparam int HP_DISC_BIT   = 3;

  // Gate-open timer width; wide enough for GATE_CYCLES up to 255
  localparam int TIMER_W = 8;

  // Fare gate FSM
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHARGE = 2'b01,
    OPEN   = 2'b10
  } gate_state_e;

endpackage

// File: rtl/toll_fare_calc.sv
// Combinational fare lookup from a 4-bit hipass card code.
// Code 4'b0000 means "no card": valid_o is low and the fare is 0.
module toll_fare_calc
  import toll_pkg::*;
(
  input  logic [3:0] hipass_i,
  output logic [7:0] fare_o,
  output logic       valid_o
);

  logic [7:0] base;

  // Exempt wins over discount; discount halves the class base fare
  always_comb begin
    valid_o = (hipass_i != 4'b0000);
    base    = FARE_TABLE[hipass_i[HP_CLASS_MSB:HP_CLASS_LSB]];
    fare_o  = base;
    if (!valid_o) begin
      fare_o = 8'd0;
    end else if (hipass_i[HP_EXEMPT_BIT]) begin
      fare_o = 8'd0;
    end else if (hipass_i[HP_DISC_BIT]) begin
      fare_o = base >> 1;
    end
  end

endmodule

// File: rtl/toll_fare_gate.sv
// Fare gate downstream of the toll-booth FSM. Each entry of state_in into
// the output state (2'b11) charges one vehicle: fare lookup, revenue and
// vehicle accumulation (both saturating), then the gate opens for
// GATE_CYCLES cycles. Triggers arriving while busy are dropped and flagged
// in the sticky overrun bit.
// Optional build macro: TOLL_RECEIPT_EN adds receipt_valid / receipt_seq.
module toll_fare_gate
  import toll_pkg::*;
#(
  parameter int GATE_CYCLES = 8,
  parameter int TOTAL_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         state_in,
  input  logic [3:0]         hipass,
  output logic [7:0]         fare,
  output logic [TOTAL_W-1:0] total,
  output logic [7:0]         vehicle_count,
  output logic               gate_open,
  output logic               busy,
  output logic               err,
  output logic               overrun
`ifdef TOLL_RECEIPT_EN
  ,
  output logic               receipt_valid,
  output logic [7:0]         receipt_seq
`endif
);

  gate_state_e        state_q;
  logic [1:0]         prev_state_q;
  logic               code_valid_q;
  logic [7:0]         fare_q;
  logic [TOTAL_W-1:0] total_q;
  logic [7:0]         count_q;
  logic               gate_q;
  logic               busy_q;
  logic               err_q;
  logic               overrun_q;
  logic [TIMER_W-1:0] timer_q;
`ifdef TOLL_RECEIPT_EN
  logic               receipt_valid_q;
  logic [7:0]         receipt_seq_q;
`endif

  logic               trigger;
  logic [7:0]         calc_fare;
  logic               calc_valid;
  logic [TOTAL_W:0]   total_sum;
  logic [TOTAL_W-1:0] total_d;
  logic [7:0]         count_d;

  toll_fare_calc u_calc (
    .hipass_i (hipass),
    .fare_o   (calc_fare),
    .valid_o  (calc_valid)
  );

  // Rising edge into the output state; a held 2'b11 fires only once
  assign trigger = (state_in == ST_OUTPUT) && (prev_state_q != ST_OUTPUT);

  // Saturating next values for the accumulators (one extra bit catches carry)
  assign total_sum = {1'b0, total_q} + {{(TOTAL_W - 7){1'b0}}, fare_q};
  assign total_d   = total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];
  assign count_d   = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  // Gate FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_state_q <= 2'b00;
      code_valid_q <= 1'b0;
      fare_q       <= 8'd0;
      total_q      <= '0;
      count_q      <= 8'd0;
      gate_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      overrun_q    <= 1'b0;
      timer_q      <= '0;
`ifdef TOLL_RECEIPT_EN
      receipt_valid_q <= 1'b0;
      receipt_seq_q   <= 8'd0;
`endif
    end else begin
      prev_state_q <= state_in;
      err_q        <= 1'b0;
`ifdef TOLL_RECEIPT_EN
      receipt_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (trigger) begin
            code_valid_q <= calc_valid;
            fare_q       <= calc_fare;
            busy_q       <= 1'b1;
            state_q      <= CHARGE;
          end
        end

        CHARGE: begin
          if (trigger) begin
            overrun_q <= 1'b1;
          end
          if (code_valid_q) begin
            total_q <= total_d;
            count_q <= count_d;
            gate_q  <= 1'b1;
            timer_q <= TIMER_W'(GATE_CYCLES - 1);
            state_q <= OPEN;
`ifdef TOLL_RECEIPT_EN
            receipt_valid_q <= 1'b1;
            receipt_seq_q   <= receipt_seq_q + 8'd1;
`endif
          end else begin
            fare_q  <= 8'd0;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        OPEN: begin
          if (timer_q == '0) begin
            // Gate closes; a trigger on this same edge starts the next vehicle
            gate_q <= 1'b0;
            if (trigger) begin
              code_valid_q <= calc_valid;
              fare_q       <= calc_fare;
              state_q      <= CHARGE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            timer_q <= timer_q - 1'b1;
            if (trigger) begin
              overrun_q <= 1'b1;
            end
          end
        end

        default: begin
          gate_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fare          = fare_q;
  assign total         = total_q;
  assign vehicle_count = count_q;
  assign gate_open     = gate_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign overrun       = overrun_q;
`ifdef TOLL_RECEIPT_EN
  assign receipt_valid = receipt_valid_q;
  assign receipt_seq   = receipt_seq_q;
`endif

endmodule

// File: tb/tb_toll_fare_gate.sv
// Directed bench for toll_fare_gate (default parameters, GATE_CYCLES=8,
// TOTAL_W=16). Inputs change and outputs are sampled 1ns after each rising
// edge, so every sample shows the values registered at that edge.
module tb_toll_fare_gate;

  logic        clk;
  logic        rst;
  logic [1:0]  state_in;
  logic [3:0]  hipass;
  logic [7:0]  fare;
  logic [15:0] total;
  logic [7:0]  vehicle_count;
  logic        gate_open;
  logic        busy;
  logic        err;
  logic        overrun;
`ifdef TOLL_RECEIPT_EN
  logic        receipt_valid;
  logic [7:0]  receipt_seq;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int hi;

  toll_fare_gate #(.GATE_CYCLES(8), .TOTAL_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .state_in      (state_in),
    .hipass        (hipass),
    .fare          (fare),
    .total         (total),
    .vehicle_count (vehicle_count),
    .gate_open     (gate_open),
    .busy          (busy),
    .err           (err),
    .overrun       (overrun)
`ifdef TOLL_RECEIPT_EN
    ,
    .receipt_valid (receipt_valid),
    .receipt_seq   (receipt_seq)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    state_in = 2'b00;
    hipass   = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  // Enter the output state for one edge (edge N), then leave it
  task automatic trig(input logic [3:0] code);
    state_in = 2'b11;
    hipass   = code;
    step();
    state_in = 2'b01;
  endtask

  // Count samples with gate high from the current one until it drops (bounded)
  task automatic wait_close(output int n);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!gate_open) break;
      n++;
      step();
    end
    check("gate_closed", {31'd0, gate_open}, 32'd0);
  endtask

  initial begin
    // ---- Reset state ----
    do_reset();
    check("rst_fare", fare, 0);
    check("rst_total", total, 0);
    check("rst_count", vehicle_count, 0);
    check("rst_gate", gate_open, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_overrun", overrun, 0);

    // ---- Scenario 1: 00->01->10->11->01, class 2 -> 30 ----
    state_in = 2'b01; step();
    state_in = 2'b10; step();
    check("s1_pre_busy", busy, 0);
    trig(4'b0010);
    check("s1_fare", fare, 30);
    check("s1_busy_n", busy, 1);
    check("s1_gate_n", gate_open, 0);
    check("s1_total_n", total, 0);
    step();
    check("s1_total", total, 30);
    check("s1_count", vehicle_count, 1);
    check("s1_gate", gate_open, 1);
    wait_close(hi);
    check("s1_gate_cycles", hi, 8);
    check("s1_busy_after", busy, 0);
    check("s1_fare_hold", fare, 30);

    // ---- Scenario 2: 4'b1011 (held 11 two edges) then 4'b0101 ----
    do_reset();
    state_in = 2'b11; hipass = 4'b1011; step();
    check("s2a_fare", fare, 20);
    step();
    state_in = 2'b01;
    check("s2a_overrun_held", overrun, 0);
    check("s2a_total", total, 20);
    check("s2a_gate", gate_open, 1);
    wait_close(hi);
    check("s2a_gate_cycles", hi, 8);
    trig(4'b0101);
    check("s2b_fare", fare, 0);
    step();
    check("s2b_total", total, 20);
    check("s2b_count", vehicle_count, 2);
    check("s2b_gate", gate_open, 1);
    wait_close(hi);
    check("s2b_gate_cycles", hi, 8);
    check("s2_overrun", overrun, 0);

    // ---- Scenario 3: no card ----
    trig(4'b0000);
    check("s3_fare_n", fare, 0);
    check("s3_busy_n", busy, 1);
    check("s3_err_n", err, 0);
    step();
    check("s3_err", err, 1);
    check("s3_fare", fare, 0);
    check("s3_gate", gate_open, 0);
    check("s3_total", total, 20);
    check("s3_count", vehicle_count, 2);
    check("s3_busy", busy, 0);
    step();
    check("s3_err_pulse", err, 0);
    check("s3_gate_later", gate_open, 0);

    // ---- Scenario 4: re-trigger 3 cycles into OPEN ----
    do_reset();
    trig(4'b0010);
    step();
    check("s4_gate", gate_open, 1);
    step(); step(); step();
    check("s4_overrun_pre", overrun, 0);
    trig(4'b0011);
    check("s4_overrun", overrun, 1);
    check("s4_gate_mid", gate_open, 1);
    wait_close(hi);
    check("s4_gate_rest", hi, 4);
    check("s4_total", total, 30);
    check("s4_count", vehicle_count, 1);
    check("s4_fare", fare, 30);
    step(); step();
    check("s4_overrun_sticky", overrun, 1);
    check("s4_busy", busy, 0);

    // ---- Scenario 5: saturation with class-3 vehicles (40 each) ----
    do_reset();
    for (int v = 0; v < 1638; v++) begin
      trig(4'b0011);
      step();
      wait_close(hi);
    end
    check("s5_total_1638", total, 65520);
    check("s5_count_1638", vehicle_count, 255);
    trig(4'b0011);
    step();
    wait_close(hi);
    check("s5_total_sat", total, 65535);
    for (int v = 1639; v < 2200; v++) begin
      trig(4'b0011);
      step();
      wait_close(hi);
    end
    check("s5_total_2200", total, 65535);
    check("s5_count_2200", vehicle_count, 255);
    check("s5_fare", fare, 40);

    // ---- Scenario 6: reset during OPEN cycle 4 ----
    trig(4'b0011);
    step();
    step(); step(); step();
    check("s6_gate_pre", gate_open, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s6_gate", gate_open, 0);
    check("s6_busy", busy, 0);
    check("s6_total", total, 0);
    check("s6_count", vehicle_count, 0);
    check("s6_fare", fare, 0);
    step();
    check("s6_gate_stay", gate_open, 0);
    trig(4'b0001);
    check("s6_new_fare", fare, 20);
    step();
    check("s6_new_total", total, 20);
    check("s6_new_count", vehicle_count, 1);
    wait_close(hi);
    check("s6_new_gate_cycles", hi, 8);

    // ---- Scenario 7: trigger on the gate-closing edge is accepted ----
    do_reset();
    trig(4'b0010);
    step();
    for (int i = 0; i < 7; i++) step();
    check("s7_gate_last", gate_open, 1);
    trig(4'b0001);
    check("s7_gate_fall", gate_open, 0);
    check("s7_busy", busy, 1);
    check("s7_fare", fare, 20);
    check("s7_overrun", overrun, 0);
    step();
    check("s7_total", total, 50);
    check("s7_count", vehicle_count, 2);
    check("s7_gate", gate_open, 1);
    wait_close(hi);
    check("s7_gate_cycles", hi, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/toll_fare_gate.md
Name: toll_fare_gate

Overview:
Sits directly downstream of the toll-booth Moore FSM (`main`). It consumes that FSM's state code and the hipass card code. It issues one transaction each time the FSM enters the output state (2'b11):
- computes the fare from the card code,
- accumulates revenue and vehicle count,
- holds the gate open for a fixed number of cycles.

Parameters:
- GATE_CYCLES, 8, cycles `gate_open` stays high per accepted vehicle (legal range 1..255).
- TOTAL_W, 16, width of the revenue accumulator.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- state_in  input  2  state code from upstream FSM; 2'b11 = output state.
- hipass  input  4  card code; [1:0] vehicle class, [2] exempt, [3] 50% discount; 4'b0000 = no card.
- fare  output  8  fare of most recent transaction, units of 100 won.
- total  output  TOTAL_W  accumulated revenue, saturating.
- vehicle_count  output  8  accepted vehicles, saturating at 255.
- gate_open  output  1  gate actuator enable.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle pulse on invalid code (4'b0000).
- overrun  output  1  sticky; set when a trigger arrives while busy.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values: fare=0, total=0, vehicle_count=0, gate_open=0, busy=0, err=0, overrun=0, FSM=IDLE, prev_state=2'b00, timer=0.
- Trigger:
  - Trigger = (state_in==2'b11) && (prev_state!=2'b11); prev_state is a registered copy of state_in.
  - A state_in held at 2'b11 for multiple cycles produces exactly one trigger.
- FSM states are IDLE, CHARGE and OPEN.
- IDLE:
  - On trigger, latch hipass, register the computed fare into `fare`, go to CHARGE.
  - busy=1 from this edge.
- CHARGE (exactly 1 cycle):
  - Latched code valid: total += fare (saturate at 2^TOTAL_W-1), vehicle_count += 1 (saturate at 255), gate_open=1, timer=GATE_CYCLES-1, go to OPEN.
  - Latched code == 0: fare=0, err=1 for one cycle, total and count unchanged, go to IDLE.
- OPEN:
  - When timer==0, gate_open=0 and go to IDLE; otherwise decrement timer.
  - gate_open is high for exactly GATE_CYCLES cycles.
- Fare rule: base = FARE_TABLE[class] (10/20/30/40).
  - exempt=1 gives 0; exempt overrides discount.
  - Otherwise discount=1 gives base>>1.
  - Otherwise base.
- Trigger while busy (CHARGE or OPEN): dropped, overrun set. Overrun clears only on rst.
- Latency: trigger sampled at edge N → fare valid after N; total/count updated and gate_open high after N+1; gate_open falls after N+1+GATE_CYCLES; next trigger accepted at that same edge.
- Reset mid-OPEN forces gate_open=0 and IDLE on that edge; accumulators clear.
- state_in values other than 2'b11 are ignored apart from edge tracking.

Optional Feature:
TOLL_RECEIPT_EN:
- Defined: adds outputs `receipt_valid` (1 bit) and `receipt_seq` (8 bits).
  - receipt_valid pulses for 1 cycle in CHARGE on valid codes.
  - receipt_seq increments (wraps 255→0) with each receipt; reset 0.
- Undefined: neither port nor its logic exists.

Decomposition:
- Shared package toll_pkg holds:
  - state codes ST_INITIAL/ST_CAR/ST_HIPASS/ST_OUTPUT (2'b00..2'b11), used here and upstream;
  - FARE_TABLE constants (10, 20, 30, 40);
  - hipass bit-field positions;
  - local FSM enum {IDLE, CHARGE, OPEN}.
- One natural sub-module: toll_fare_calc, a combinational fare lookup from the 4-bit code.

Test Plan:
- state_in 00→01→10→11→01, hipass=4'b0010 → fare=30, total=30, vehicle_count=1, gate_open high exactly 8 cycles starting 2 edges after trigger, busy cleared after.
- hipass=4'b1011 then, after idle, 4'b0101 → fares 20 then 0; total=20, vehicle_count=2, gate opens both times.
- hipass=4'b0000 at output state → err pulse 1 cycle, fare=0, total/count unchanged, gate_open never asserts.
- Second 2'b11 entry 3 cycles into OPEN → ignored, overrun=1 and stays 1; gate closes on original schedule; total counts once.
- Preload via 2200 class-3 vehicles (40 each) → total saturates at 65535, vehicle_count saturates at 255.
- Assert rst during OPEN cycle 4 → next edge gate_open=0, busy=0, all accumulators 0; fresh trigger then processed normally.
